// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
//
// Control unit for the sweep sequential adder inside the signed shift-add
// multiplier. A start request captures two DW-bit two's-complement operands,
// converts them to magnitudes, steps the adder through DW sweep cycles, then
// removes the adder's residual accumulator value, restores the sign and
// presents the 2*DW-bit signed product with a one-cycle ready pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low
//   start          operation request, sampled only in IDLE or DONE
//   multiplicand   signed operand A (DW bits)
//   multiplier     signed operand B (DW bits)
//   adder_done     done flag from the sweep adder
//   adder_product  accumulator of the sweep adder (2*DW bits)
//   l_s            adder counter clear
//   init_FSM       adder enable
//   permit         adder hold; 1 freezes the accumulator
//   rgstr1         |B|, swept bit by bit by the adder
//   rgstr2         |A| shifted left by the current sweep index
//   busy           high from LOAD through FIX
//   ready          one-cycle pulse, result valid
//   result         signed product, held until the next FIX
//   err            sticky: adder_done was low in FIX; cleared on accepted start
// -----------------------------------------------------------------------------
module mult_sequencer #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  input  logic            adder_done,
  input  logic [2*DW-1:0] adder_product,
  output logic            l_s,
  output logic            init_FSM,
  output logic            permit,
  output logic [DW-1:0]   rgstr1,
  output logic [2*DW-1:0] rgstr2,
  output logic            busy,
  output logic            ready,
  output logic [2*DW-1:0] result,
  output logic            err
);

  localparam int PW = 2 * DW;
  localparam int KW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            neg;
  logic [PW-1:0]   base;

  // Magnitudes are taken as unsigned DW-bit values, so the most negative
  // operand maps onto 2^(DW-1) without overflow.
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic [PW-1:0]   mag_p;
  logic [PW-1:0]   signed_p;

  assign mag_a    = multiplicand[DW-1] ? (~multiplicand + DW'(1)) : multiplicand;
  assign mag_b    = multiplier[DW-1]   ? (~multiplier   + DW'(1)) : multiplier;
  // The adder accumulator is never cleared between operations, so the value
  // captured in LOAD is subtracted to isolate this operation's sum.
  assign mag_p    = adder_product - base;
  // Negating zero yields zero, so a zero product never comes out as -0.
  assign signed_p = neg ? (PW'(0) - mag_p) : mag_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k        <= '0;
      neg      <= 1'b0;
      base     <= '0;
      l_s      <= 1'b0;
      init_FSM <= 1'b0;
      permit   <= 1'b1;
      rgstr1   <= '0;
      rgstr2   <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      init_FSM <= 1'b1;
      ready    <= 1'b0;
      case (state)
        IDLE, DONE: begin
          permit <= 1'b1;
          l_s    <= 1'b0;
          if (start) begin
            rgstr1 <= mag_b;
            rgstr2 <= {{DW{1'b0}}, mag_a};
            neg    <= multiplicand[DW-1] ^ multiplier[DW-1];
            busy   <= 1'b1;
            err    <= 1'b0;
            l_s    <= 1'b1;
            state  <= LOAD;
          end else begin
            state  <= IDLE;
          end
        end

        LOAD: begin
          base   <= adder_product;
          l_s    <= 1'b0;
          permit <= 1'b0;
          k      <= '0;
          state  <= RUN;
        end

        RUN: begin
          // adder_done is stale here; only the sweep count ends RUN.
          rgstr2 <= rgstr2 << 1;
          if (k == K_LAST) begin
            permit <= 1'b1;
            state  <= FIX;
          end else begin
            k <= k + KW'(1);
          end
        end

        FIX: begin
          result <= signed_p;
          if (!adder_done) begin
            err <= 1'b1;
          end
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
//
// Directed bench for mult_sequencer with a behavioural sweep adder. Expected
// products are pushed to a scoreboard when start is driven and compared when
// ready pulses.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

  localparam int DW = 16;
  localparam int PW = 2 * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [DW-1:0]   multiplicand = '0;
  logic [DW-1:0]   multiplier = '0;
  logic            adder_done;
  logic [PW-1:0]   adder_product;
  logic            l_s;
  logic            init_FSM;
  logic            permit;
  logic [DW-1:0]   rgstr1;
  logic [PW-1:0]   rgstr2;
  logic            busy;
  logic            ready;
  logic [PW-1:0]   result;
  logic            err;

  mult_sequencer #(.DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .adder_done    (adder_done),
    .adder_product (adder_product),
    .l_s           (l_s),
    .init_FSM      (init_FSM),
    .permit        (permit),
    .rgstr1        (rgstr1),
    .rgstr2        (rgstr2),
    .busy          (busy),
    .ready         (ready),
    .result        (result),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Behavioural sweep adder: accumulator cleared only by rst, counter cleared
  // by l_s, adds rgstr2 when rgstr1[cnt] is set while enabled and not held.
  logic [PW-1:0] acc;
  logic [4:0]    cnt;
  logic          mdone;
  logic          force_low = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      cnt   <= '0;
      mdone <= 1'b0;
    end else if (l_s) begin
      cnt   <= '0;
      mdone <= 1'b0;
    end else if (init_FSM && !permit) begin
      if (rgstr1[cnt[3:0]]) acc <= acc + rgstr2;
      cnt <= cnt + 5'd1;
      if (cnt == 5'(DW - 1)) mdone <= 1'b1;
    end
  end

  assign adder_done    = mdone & ~force_low;
  assign adder_product = acc;

  typedef struct packed {
    logic [PW-1:0] res;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   op_no  = 0;

  function automatic logic [PW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] p;
    p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Caller is at a negedge; start is sampled at the next posedge (E0) and the
  // task returns at the negedge after E0 with operands scrambled.
  task automatic drive_start(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic e);
    exp_t x;
    x.res = prod(a, b);
    x.e   = e;
    sb.push_back(x);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
  endtask

  task automatic wait_ready(output int cyc, output int busy_lo);
    cyc     = 0;
    busy_lo = 0;
    while (ready !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) busy_lo++;
      @(negedge clk);
      cyc++;
    end
    chk("ready_seen", 64'(ready), 64'd1);
  endtask

  task automatic check_result();
    exp_t x;
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      op_no++;
      $display("op %0d: result=%h err=%b expected result=%h err=%b", op_no, result, err, x.res, x.e);
      chk("result", 64'(result), 64'(x.res));
      chk("err", 64'(err), 64'(x.e));
    end
    chk("busy_at_ready", 64'(busy), 64'd0);
  endtask

  task automatic count_ready(input int n, output int cnt_r);
    cnt_r = 0;
    repeat (n) begin
      @(negedge clk);
      if (ready === 1'b1) cnt_r++;
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic e);
    int c;
    int bl;
    drive_start(a, b, e);
    wait_ready(c, bl);
    chk("latency", 64'(c), 64'(DW + 2));
    check_result();
    @(negedge clk);
    chk("ready_pulse", 64'(ready), 64'd0);
  endtask

  initial begin
    int c;
    int bl;
    int nr;
    logic [PW-1:0] held;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({l_s, init_FSM, permit, busy, ready, err}), 64'b001000);
    chk("rst_rgstr1", 64'(rgstr1), 64'd0);
    chk("rst_rgstr2", 64'(rgstr2), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ctrl", 64'({l_s, init_FSM, permit, busy}), 64'b0110);

    // 3 x 5 with capture, sweep and latency checks
    drive_start(16'd3, 16'd5, 1'b0);
    chk("load_rgstr1", 64'(rgstr1), 64'd5);
    chk("load_rgstr2", 64'(rgstr2), 64'd3);
    chk("load_ctrl", 64'({l_s, permit, busy}), 64'b111);
    repeat (3) @(negedge clk);
    chk("run2_rgstr2", 64'(rgstr2), 64'd12);
    chk("run_ctrl", 64'({l_s, permit, busy}), 64'b001);
    wait_ready(c, bl);
    chk("latency_first", 64'(c + 3), 64'(DW + 2));
    chk("busy_during_op", 64'(bl), 64'd0);
    check_result();
    @(negedge clk);
    held = result;
    chk("ready_pulse_first", 64'(ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("result_held", 64'(result), 64'(held));

    // Sign handling and boundary operands
    run_op(16'hFFFD, 16'd5,    1'b0);
    run_op(16'd5,    16'hFFFD, 1'b0);
    run_op(16'hFFFD, 16'hFFFB, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);
    run_op(16'h7FFF, 16'h8000, 1'b0);
    run_op(16'h0000, 16'h8000, 1'b0);

    // Back-to-back: second start issued in DONE
    drive_start(16'd3, 16'd5, 1'b0);
    wait_ready(c, bl);
    check_result();
    drive_start(16'd7, 16'd7, 1'b0);
    wait_ready(c, bl);
    chk("b2b_gap", 64'(c + 1), 64'(DW + 3));
    check_result();
    @(negedge clk);

    // start during RUN k=4 is ignored
    drive_start(16'd9, 16'd11, 1'b0);
    repeat (5) @(negedge clk);
    start        = 1'b1;
    multiplicand = 16'd2;
    multiplier   = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_ready(c, bl);
    chk("latency_ignored", 64'(c + 6), 64'(DW + 2));
    check_result();
    count_ready(25, nr);
    chk("no_extra_ready", 64'(nr), 64'd0);

    // Reset during RUN k=8
    drive_start(16'd4, 16'd4, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({l_s, init_FSM, permit, busy, ready, err}), 64'b001000);
    chk("midrst_regs", 64'({rgstr1, rgstr2}), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    count_ready(25, nr);
    chk("midrst_no_ready", 64'(nr), 64'd0);
    run_op(16'd6, 16'd7, 1'b0);

    // adder_done low in FIX sets err; next accepted start clears it
    force_low = 1'b1;
    run_op(16'hFFF9, 16'd9, 1'b1);
    force_low = 1'b0;
    chk("err_sticky", 64'(err), 64'd1);
    drive_start(16'd2, 16'd3, 1'b0);
    chk("err_cleared", 64'(err), 64'd0);
    wait_ready(c, bl);
    check_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Control unit for the sweep sequential adder in the signed shift-add multiplier. It accepts a start request with two DW-bit two's-complement operands and converts them to magnitudes. It drives the adder's l_s/init_FSM/permit/rgstr1/rgstr2 inputs for exactly DW sweep cycles, then applies the sign correction and presents the 2·DW-bit signed product with a one-cycle ready pulse. It sits between the top-level operand/start interface and the adder instance.

## Interface
- DW, 16, operand width; product width is 2·DW.
- Reset rst is asynchronous and active-low; the clock is clk.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplicand  in  DW  signed operand A.
- multiplier  in  DW  signed operand B.
- adder_done  in  1  done from the sweep adder.
- adder_product  in  2·DW  accumulator from the sweep adder.
- l_s  out  1  adder counter clear.
- init_FSM  out  1  adder enable.
- permit  out  1  adder hold; 1 freezes the accumulator.
- rgstr1  out  DW  |B|, swept by the adder.
- rgstr2  out  2·DW  |A| shifted left by the current sweep index.
- busy  out  1  high from LOAD through FIX.
- ready  out  1  one-cycle pulse; result valid.
- result  out  2·DW  signed product, held until the next FIX.
- err  out  1  sticky; adder_done was low in FIX; cleared on accepted start.

## Operation
- Reset values: l_s=0, init_FSM=0, permit=1, rgstr1=0, rgstr2=0, busy=0, ready=0, result=0, err=0, state=IDLE, k=0.
- All outputs are registered.
- IDLE: init_FSM=1, permit=1, l_s=0. On start=1, capture the operands and go to LOAD.
- Capture (same edge):
  - rgstr1 = |B|.
  - rgstr2 = zero-extended |A|.
  - neg = A[DW-1] XOR B[DW-1].
  - Magnitude of −2^(DW-1) is 2^(DW-1), unsigned, with no overflow.
  - busy=1, err=0, l_s=1.
- LOAD (1 cycle): l_s=1, permit=1. Capture base = adder_product at the end of the cycle. The adder accumulator is cleared only by rst, so base removes residue from prior operations. Then l_s=0, permit=0, k=0, go to RUN.
- RUN (DW cycles, k=0..DW-1):
  - permit=0.
  - rgstr2 = |A|<<k during cycle k; it shifts left by 1 at the end of each RUN cycle.
  - After k=DW-1: permit=1, go to FIX.
  - adder_done is ignored in RUN because it is stale from the previous operation.
- FIX (1 cycle):
  - mag = adder_product − base, modulo 2^(2·DW).
  - result = neg ? (~mag+1) : mag. Zero magnitude yields 0 regardless of neg.
  - If adder_done=0, set err=1; result is still written.
  - Go to DONE.
- DONE (1 cycle): ready=1, busy=0. start=1 here is accepted exactly as in IDLE, going to LOAD with ready=1 for this cycle only. Otherwise go to IDLE.
- start in LOAD, RUN or FIX is ignored; it is not queued.
- Operand inputs are sampled only at the capture edge.
- Reset mid-operation: all outputs and state return to reset values immediately. The result of the interrupted operation is discarded.

## Timing
- Edge E0 samples start. LOAD spans E0–E1. RUN k spans E(1+k)–E(2+k). FIX spans E(DW+1)–E(DW+2). ready is high E(DW+2)–E(DW+3).
- Latency from the start-sampling edge to ready rising: DW+2 cycles (18 for DW=16).
- Back-to-back throughput: one product per DW+3 cycles, with start held or re-asserted in DONE.
- The adder adds rgstr2 on the edge ending RUN k when rgstr1[k]=1. Its last add and done rise at E(DW+1), so adder_product is final throughout FIX.
- result changes only at the edge ending FIX. It is stable in DONE and IDLE.

## Test plan
- DW=16: A=3, B=5, single start after reset -> ready at E18, result=0x0000000F, err=0, busy high E0–E18.
- A=−3 (0xFFFD), B=5 -> result=0xFFFFFFF1. Then A=5, B=−3 -> same result; A=−3, B=−5 -> 0x0000000F.
- A=B=0x8000 -> result=0x40000000. Then A=0x7FFF, B=0x8000 -> 0xC0008000. Then A=0, B=0x8000 -> 0x00000000.
- Back-to-back: 3×5 followed by 7×7, with the second start in DONE -> results 15 then 49, with base correctly removing the residual 15. The second ready arrives 19 cycles after the first.
- start pulsed during RUN k=4 with different operands -> ignored; result of the original operation unchanged, one ready pulse only.
- rst asserted at RUN k=8 -> all outputs at reset values the same cycle, no ready. A subsequent 6×7 -> 42.
- Adder model forcing adder_done=0 in FIX -> err=1 after FIX, cleared by the next accepted start.
